// File: rtl/cpu_phase_pkg.sv
// Shared types and constants for the CPU phase sequencer.
// The optional phase-order checker is built when PHASE_CHECK_EN is defined.
package cpu_phase_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } seq_state_e;

  // Phase codes produced by the three-phase divider (0 is never produced)
  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_FETCH  = 2'd1;
  localparam logic [1:0] PH_DECODE = 2'd2;
  localparam logic [1:0] PH_EXEC   = 2'd3;

  // Code the divider must produce after ph; an idle code is followed by fetch
  function automatic logic [1:0] phase_succ(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_FETCH:  nxt = PH_DECODE;
      PH_DECODE: nxt = PH_EXEC;
      default:   nxt = PH_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_phase_wait_timer.sv
// Counts consecutive not-ready decode slots while the sequencer waits on memory.
// o_EXPIRE flags, combinationally, that the increment being requested now
// brings the count to MAX_WAIT.
module cpu_phase_wait_timer #(
  parameter int MAX_WAIT = 4
) (
  input  logic i_CLOCK,
  input  logic i_RESET_N,
  input  logic i_CLEAR,
  input  logic i_INC,
  output logic o_EXPIRE
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d, base;

  // Clear takes effect before a same-cycle increment, so clear+inc loads 1
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally) so no latch is inferred.
  always_comb begin
    base     = i_CLEAR ? '0 : cnt_q;
    cnt_d    = i_INC ? base + CW'(1) : base;
    o_EXPIRE = i_INC && (base == CW'(MAX_WAIT - 1));
  end

  // Wait counter register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Turns the divider's phase code into registered FETCH/DECODE/EXEC enables,
// with memory wait-state stall, wait timeout (sticky bus error),
// instruction-boundary halt and a retired-instruction counter.
// Optional: define PHASE_CHECK_EN to add o_PHASE_ERR and phase-order checking.
module cpu_phase_sequencer
  import cpu_phase_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_WAIT    = 4
) (
  input  logic                   i_CLOCK,
  input  logic                   i_RESET_N,
  input  logic [1:0]             i_STATE,
  input  logic                   i_MEM_READY,
  input  logic                   i_HALT_REQ,
  output logic                   o_FETCH_EN,
  output logic                   o_DECODE_EN,
  output logic                   o_EXEC_EN,
  output logic                   o_STALL,
  output logic                   o_HALTED,
  output logic                   o_BUS_ERR,
  output logic [COUNT_WIDTH-1:0] o_INSN_COUNT
`ifdef PHASE_CHECK_EN
  ,
  output logic                   o_PHASE_ERR
`endif
);

  seq_state_e             state_q, state_d;
  logic                   fetch_q, fetch_d;
  logic                   decode_q, decode_d;
  logic                   exec_q, exec_d;
  logic                   stall_q, stall_d;
  logic                   halted_q, halted_d;
  logic                   bus_err_q, bus_err_d;
  logic                   decoded_q, decoded_d;   // decode done, EXEC owed at slot 3
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic phase_bad;
  logic wait_clr, wait_inc, wait_expire;

`ifdef PHASE_CHECK_EN
  logic [1:0] prev_q;
  logic       prev_vld_q;
  logic       phase_err_q, phase_err_d;

  // Out-of-order code: anything but the successor of the last sample (0 never is)
  assign phase_bad = (i_STATE == PH_IDLE) ||
                     (prev_vld_q && (i_STATE != phase_succ(prev_q)));
`else
  assign phase_bad = 1'b0;
`endif

  // Counter only matters inside STALL; it is held at zero everywhere else
  assign wait_clr = (state_q != STALL);
  assign wait_inc = !phase_bad && (i_STATE == PH_DECODE) && !i_MEM_READY &&
                    ((state_q == RUN) || (state_q == STALL));

  cpu_phase_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .i_CLOCK   (i_CLOCK),
    .i_RESET_N (i_RESET_N),
    .i_CLEAR   (wait_clr),
    .i_INC     (wait_inc),
    .o_EXPIRE  (wait_expire)
  );

  // Next-state and next-output decode for the sampled phase code
  always_comb begin
    state_d   = state_q;
    fetch_d   = 1'b0;
    decode_d  = 1'b0;
    exec_d    = 1'b0;
    bus_err_d = bus_err_q;
    decoded_d = decoded_q;
    count_d   = count_q;
`ifdef PHASE_CHECK_EN
    phase_err_d = phase_err_q | phase_bad;
`endif

    if (phase_bad) begin
      decoded_d = 1'b0;
      if (state_q != HALT) state_d = SYNC;
    end else begin
      case (state_q)
        SYNC: begin
          if (i_STATE == PH_EXEC) begin
            state_d   = RUN;
            decoded_d = 1'b0;
          end
        end
        RUN: begin
          case (i_STATE)
            PH_FETCH: begin
              fetch_d   = 1'b1;
              decoded_d = 1'b0;
            end
            PH_DECODE: begin
              if (i_MEM_READY) begin
                decode_d  = 1'b1;
                decoded_d = 1'b1;
              end else if (wait_expire) begin
                bus_err_d = 1'b1;
                state_d   = HALT;
              end else begin
                state_d = STALL;
              end
            end
            PH_EXEC: begin
              if (decoded_q) begin
                exec_d    = 1'b1;
                count_d   = count_q + COUNT_WIDTH'(1);
                decoded_d = 1'b0;
              end
              if (i_HALT_REQ) state_d = HALT;
            end
            default: ;
          endcase
        end
        STALL: begin
          if (i_STATE == PH_DECODE) begin
            if (i_MEM_READY) begin
              decode_d  = 1'b1;
              decoded_d = 1'b1;
              state_d   = RUN;
            end else if (wait_expire) begin
              bus_err_d = 1'b1;
              state_d   = HALT;
            end
          end
        end
        HALT: begin
          if (!i_HALT_REQ && !bus_err_q) state_d = SYNC;
        end
        default: state_d = SYNC;
      endcase
    end

    stall_d  = (state_d == STALL);
    halted_d = (state_d == HALT);
  end

  // FSM state and all registered outputs
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q   <= SYNC;
      fetch_q   <= 1'b0;
      decode_q  <= 1'b0;
      exec_q    <= 1'b0;
      stall_q   <= 1'b0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
      decoded_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetch_q   <= fetch_d;
      decode_q  <= decode_d;
      exec_q    <= exec_d;
      stall_q   <= stall_d;
      halted_q  <= halted_d;
      bus_err_q <= bus_err_d;
      decoded_q <= decoded_d;
      count_q   <= count_d;
    end
  end

`ifdef PHASE_CHECK_EN
  // Last sampled phase code and sticky phase error
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      prev_q      <= PH_IDLE;
      prev_vld_q  <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      prev_q      <= i_STATE;
      prev_vld_q  <= 1'b1;
      phase_err_q <= phase_err_d;
    end
  end

  assign o_PHASE_ERR = phase_err_q;
`endif

  assign o_FETCH_EN   = fetch_q;
  assign o_DECODE_EN  = decode_q;
  assign o_EXEC_EN    = exec_q;
  assign o_STALL      = stall_q;
  assign o_HALTED     = halted_q;
  assign o_BUS_ERR    = bus_err_q;
  assign o_INSN_COUNT = count_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Scoreboard bench for cpu_phase_sequencer (COUNT_WIDTH=4, MAX_WAIT=4).
// The driver applies one phase code per falling edge and queues the outputs
// expected after the following rising edge; a monitor pops and compares.
module tb_cpu_phase_sequencer;

  localparam int CW = 4;
  localparam int MW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    st    = 2'd0;
  logic          ready = 1'b1;
  logic          hreq  = 1'b0;
  logic          f_en, d_en, e_en, stall, halted, berr;
  logic [CW-1:0] cnt;
  logic          perr;

  cpu_phase_sequencer #(.COUNT_WIDTH(CW), .MAX_WAIT(MW)) dut (
    .i_CLOCK      (clk),
    .i_RESET_N    (rst_n),
    .i_STATE      (st),
    .i_MEM_READY  (ready),
    .i_HALT_REQ   (hreq),
    .o_FETCH_EN   (f_en),
    .o_DECODE_EN  (d_en),
    .o_EXEC_EN    (e_en),
    .o_STALL      (stall),
    .o_HALTED     (halted),
    .o_BUS_ERR    (berr),
    .o_INSN_COUNT (cnt)
`ifdef PHASE_CHECK_EN
    ,
    .o_PHASE_ERR  (perr)
`endif
  );

`ifndef PHASE_CHECK_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic          f, d, e, stl, hlt, ber, per;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t   exp_q[$];
  string  name_q[$];
  int     tests = 0;
  int     fails = 0;
  logic [CW-1:0] cnt_m  = '0;
  logic          perr_m = 1'b0;

  function automatic obs_t sample();
    obs_t o;
    o.f = f_en; o.d = d_en; o.e = e_en; o.stl = stall; o.hlt = halted;
    o.ber = berr; o.per = perr; o.cnt = cnt;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got F%b D%b E%b stall%b halt%b berr%b perr%b cnt=%0d, required F%b D%b E%b stall%b halt%b berr%b perr%b cnt=%0d",
               name, act.f, act.d, act.e, act.stl, act.hlt, act.ber, act.per, act.cnt,
               exp.f, exp.d, exp.e, exp.stl, exp.hlt, exp.ber, exp.per, exp.cnt);
    end
  endtask

  // Apply one phase code at the current falling edge and queue the expected response
  task automatic slot(input logic [1:0] code, input logic rdy, input logic hr,
                      input logic f, input logic d, input logic e,
                      input logic stl, input logic hlt, input logic ber,
                      input string name);
    obs_t x;
    st = code; ready = rdy; hreq = hr;
    if (e) cnt_m = cnt_m + 1'b1;
    x.f = f; x.d = d; x.e = e; x.stl = stl; x.hlt = hlt; x.ber = ber;
    x.per = perr_m; x.cnt = cnt_m;
    exp_q.push_back(x);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  // One fault-free instruction: F, D, E
  task automatic triple(input string name);
    slot(2'd1, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0, {name, " fetch"});
    slot(2'd2, 1'b1, 1'b0, 0, 1, 0, 0, 0, 0, {name, " decode"});
    slot(2'd3, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0, {name, " exec"});
  endtask

  // Divider cycle seen while in SYNC: no enables, RUN after the slot 3
  task automatic resync(input string name);
    slot(2'd1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, {name, " sync1"});
    slot(2'd2, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, {name, " sync2"});
    slot(2'd3, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, {name, " sync3"});
  endtask

  // Assert reset at a falling edge, check the outputs drop at once, release next falling edge
  task automatic do_reset(input string name);
    obs_t z;
    z = '0;
    rst_n = 1'b0; st = 2'd0; ready = 1'b1; hreq = 1'b0;
    #1;
    check({name, " reset outputs"}, sample(), z);
    @(negedge clk);
    rst_n  = 1'b1;
    cnt_m  = '0;
    perr_m = 1'b0;
  endtask

  // Monitor: one queued expectation per rising edge, compared just after it
  initial begin
    obs_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, sample(), e);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t pre;
    @(negedge clk);
    do_reset("t1");

    // Free-running divider, memory always ready
    resync("t1");
    for (int i = 0; i < 10; i++) triple($sformatf("t1 insn%0d", i));
`ifndef PHASE_CHECK_EN
    slot(2'd0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, "t1 idle code");
`endif

    // Two not-ready decode slots, ready on the third
    slot(2'd1, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0, "t2 fetch");
    slot(2'd2, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, "t2 wait1");
    slot(2'd3, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, "t2 no exec");
    slot(2'd1, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, "t2 no refetch");
    slot(2'd2, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, "t2 wait2");
    slot(2'd3, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, "t2 stall exec");
    slot(2'd1, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, "t2 stall fetch");
    slot(2'd2, 1'b1, 1'b0, 0, 1, 0, 0, 0, 0, "t2 late decode");
    slot(2'd3, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0, "t2 exec");

    // Memory never ready: bus error on the fourth not-ready decode slot
    slot(2'd1, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0, "t3 fetch");
    for (int w = 1; w < MW; w++) begin
      slot(2'd2, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, $sformatf("t3 wait%0d", w));
      slot(2'd3, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, $sformatf("t3 wait%0d s3", w));
      slot(2'd1, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, $sformatf("t3 wait%0d s1", w));
    end
    slot(2'd2, 1'b0, 1'b0, 0, 0, 0, 0, 1, 1, "t3 timeout");
    for (int i = 0; i < 2; i++) begin
      slot(2'd3, 1'b1, 1'b0, 0, 0, 0, 0, 1, 1, "t3 held s3");
      slot(2'd1, 1'b1, 1'b0, 0, 0, 0, 0, 1, 1, "t3 held s1");
      slot(2'd2, 1'b1, 1'b0, 0, 0, 0, 0, 1, 1, "t3 held s2");
    end
    do_reset("t3");

    // Halt request across decode/exec: exec still issued, then halt, release, resync
    resync("t4");
    slot(2'd1, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0, "t4 fetch");
    slot(2'd2, 1'b1, 1'b1, 0, 1, 0, 0, 0, 0, "t4 decode+req");
    slot(2'd3, 1'b1, 1'b1, 0, 0, 1, 0, 1, 0, "t4 exec+halt");
    slot(2'd1, 1'b1, 1'b1, 0, 0, 0, 0, 1, 0, "t4 halted");
    slot(2'd2, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, "t4 release");
    slot(2'd3, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, "t4 resync");
    slot(2'd1, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0, "t4 first after halt");

    // Reset while FETCH is high
    pre = sample();
    tests++;
    if (pre.f !== 1'b1) begin
      fails++;
      $display("FAIL t5 pre-reset fetch: got %b, required 1", pre.f);
    end
    do_reset("t5");

    // 17 instructions on a 4-bit counter: wraps 15 -> 0, reads 1
    resync("t6");
    for (int i = 0; i < 17; i++) triple($sformatf("t6 insn%0d", i));

`ifdef PHASE_CHECK_EN
    // Out-of-order code 1,3: error, no exec, recovery after the next slot 3
    slot(2'd1, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0, "t7 fetch");
    perr_m = 1'b1;
    slot(2'd3, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, "t7 skip decode");
    resync("t7");
    triple("t7 recovered");
`endif

    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
Sits directly downstream of the three-phase clock divider. It samples the divider's 2-bit phase code, which cycles 1→2→3→1 with one code per i_CLOCK period. From that code it issues registered one-cycle FETCH / DECODE / EXECUTE enables to the Forth core datapath. It adds a memory wait-state stall, a wait timeout, instruction-boundary halt and a retired-instruction counter.

Parameters:
COUNT_WIDTH, 16, width of retired-instruction counter o_INSN_COUNT (wraps).
MAX_WAIT, 4, number of consecutive not-ready decode slots tolerated before bus error (≥1).

Ports:
i_CLOCK  in  1  system clock; same clock as the divider.
i_RESET_N  in  1  asynchronous active-low reset.
i_STATE  in  2  phase code from the divider: 1=fetch slot, 2=decode slot, 3=execute slot. Changes on the falling edge; stable at the rising edge.
i_MEM_READY  in  1  instruction memory has returned the fetched word.
i_HALT_REQ  in  1  level request to halt at the next instruction boundary.
o_FETCH_EN  out  1  one-cycle fetch enable.
o_DECODE_EN  out  1  one-cycle decode enable.
o_EXEC_EN  out  1  one-cycle execute/writeback enable.
o_STALL  out  1  high while waiting on memory.
o_HALTED  out  1  high while in HALT.
o_BUS_ERR  out  1  sticky; set on wait timeout.
o_INSN_COUNT  out  COUNT_WIDTH  retired instructions (count of EXEC pulses).

Behaviour:
- Reset (async assert, sync release): FSM=SYNC; all outputs 0; wait counter 0.
- All outputs are registered. Each enable is asserted in the cycle after the rising edge at which the matching i_STATE is sampled (latency 1).
- SYNC: no enables. On sampling i_STATE==3, go to RUN, so the first issued slot is a fetch.
- RUN:
  - Sample 1 → o_FETCH_EN=1 next cycle.
  - Sample 2 with i_MEM_READY=1 → o_DECODE_EN=1.
  - Sample 2 with i_MEM_READY=0 → go to STALL and set o_STALL=1. This cycle's DECODE and the following EXEC are suppressed. Wait counter becomes 1.
  - Sample 3 after a successful decode → o_EXEC_EN=1 and o_INSN_COUNT increments. The counter wraps from all-ones to 0.
- STALL:
  - No FETCH is reissued; the fetch stays outstanding. All slot-1 and slot-3 samples are ignored.
  - At each slot-2 sample: if i_MEM_READY=1, clear o_STALL, assert o_DECODE_EN, return to RUN (EXEC follows at slot 3). Otherwise increment the wait counter.
  - When the wait counter reaches MAX_WAIT: set o_BUS_ERR (sticky until reset), clear o_STALL, go to HALT.
- Halt: i_HALT_REQ is checked only at the slot-3 sample in RUN, after that EXEC has been issued. If high, go to HALT and set o_HALTED=1 next cycle. A halt request raised during STALL is deferred until the instruction completes.
- HALT: no enables. When i_HALT_REQ=0 and o_BUS_ERR=0, clear o_HALTED and go to SYNC, which resynchronises on the next slot 3. A bus error holds HALT until reset.
- At most one of FETCH/DECODE/EXEC is high in any cycle.
- Reset asserted mid-instruction: all enables drop immediately (async). There is no partial-instruction completion.
- i_STATE==0 (divider never produces this): see optional feature.

Optional Feature:
PHASE_CHECK_EN
- Defined: adds output o_PHASE_ERR (1 bit, sticky until reset, reset 0) and tracks the expected next code. Any sample that is not the successor of the previous code (including 0) sets o_PHASE_ERR, suppresses enables, and forces SYNC. A HALT state is kept.
- Not defined: no port and no check; code 0 is an idle slot (no enable, no state change).

Decomposition:
- Package cpu_phase_pkg:
  - FSM state enum (SYNC, RUN, STALL, HALT).
  - Phase code localparams PH_FETCH=2'd1, PH_DECODE=2'd2, PH_EXEC=2'd3.
  - Successor function for the phase code.
- One natural sub-module, cpu_phase_wait_timer: the wait counter with clear/increment/expire. Everything else stays in one FSM module.

Test Plan:
- Reset, free-running divider, i_MEM_READY=1 → first FETCH one cycle after the first slot-1 sample following a slot 3; repeating F,D,E pulses; o_INSN_COUNT=10 after 10 triples.
- i_MEM_READY=0 for 2 decode slots, MAX_WAIT=4 → o_STALL high; no FETCH reissued; DECODE at the 3rd slot 2, then EXEC; count +1; o_BUS_ERR=0.
- i_MEM_READY held 0, MAX_WAIT=4 → o_BUS_ERR=1 at the 4th not-ready slot 2; o_HALTED=1; stays halted after ready returns until reset.
- i_HALT_REQ pulsed during DECODE → EXEC still issued; o_HALTED=1 the cycle after the slot-3 sample; release → resync, next enable is a FETCH.
- COUNT_WIDTH=4, 17 instructions → o_INSN_COUNT wraps 15→0, reads 1.
- PHASE_CHECK_EN defined, inject i_STATE sequence 1,3 → o_PHASE_ERR=1; no EXEC issued; recovery to RUN after the next slot 3.
